// File: rtl/hpc_pkg.sv
// hpc_pkg: shared types and constants for the HPC fresh-randomness source.
package hpc_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2
  } hpc_rand_state_e;

  localparam int unsigned HPC_LFSR_W        = 64;
  localparam int unsigned HPC_RAND_W        = 6;
  localparam int unsigned HPC_WARMUP_CYCLES = 16;
  localparam int unsigned HPC_HEALTH_LIMIT  = 8;

  // x^64 + x^63 + x^61 + x^60 + 1, Galois right-shift form
  localparam logic [63:0] LFSR_TAPS_64  = 64'hD800_0000_0000_0000;
  // Substituted for an all-zero seed so the LFSR never locks up
  localparam logic [63:0] LFSR_ZERO_FIX = 64'h0000_0000_0000_0001;

  // Fewest warm-up cycles that flush every seed bit through the output window
  function automatic int unsigned min_warmup(input int unsigned lfsr_w,
                                             input int unsigned rand_w);
    return (lfsr_w + rand_w - 1) / rand_w;
  endfunction

endpackage

// File: rtl/hpc_rand_source_if.sv
// hpc_rand_source_if: seed handshake and randomness bus between the source and its consumer.
interface hpc_rand_source_if
  import hpc_pkg::*;
#(
  parameter int unsigned LFSR_W = HPC_LFSR_W,
  parameter int unsigned RAND_W = HPC_RAND_W
);

  logic [LFSR_W-1:0] io_seed;
  logic              io_seed_valid;
  logic              io_seed_ready;
  logic              io_rand_en;
  logic [RAND_W-1:0] p_rand;
  logic              io_rand_valid;
  logic              io_health_fail;

  // Consumer side: offers seeds, requests steps, receives randomness
  modport master (
    output io_seed, io_seed_valid, io_rand_en,
    input  io_seed_ready, p_rand, io_rand_valid, io_health_fail
  );

  // Source side
  modport slave (
    input  io_seed, io_seed_valid, io_rand_en,
    output io_seed_ready, p_rand, io_rand_valid, io_health_fail
  );

endinterface

// File: rtl/hpc_lfsr_step.sv
// hpc_lfsr_step: STEPS-fold unrolled Galois right-shift LFSR update, purely combinational.
module hpc_lfsr_step #(
  parameter int unsigned LFSR_W = 64,
  parameter int unsigned STEPS  = 6
) (
  input  logic [LFSR_W-1:0] state_i,
  input  logic [LFSR_W-1:0] taps_i,
  output logic [LFSR_W-1:0] state_o
);

  // Each step shifts right and folds the taps in when the bit leaving is 1
  always_comb begin
    state_o = state_i;
    for (int unsigned i = 0; i < STEPS; i++) begin
      state_o = state_o[0] ? ((state_o >> 1) ^ taps_i) : (state_o >> 1);
    end
  end

endmodule

// File: rtl/hpc_rand_source.sv
// hpc_rand_source: fresh-randomness supplier for the order-2 HPC masked AND gadgets.
// Galois LFSR with seed handshake, post-seed warm-up and stall control; p_rand,
// io_rand_valid and io_seed_ready are all registered.
// Build option: define HPC_RAND_HEALTH_EN to add the sticky stuck-output health alarm.
module hpc_rand_source
  import hpc_pkg::*;
#(
  parameter int unsigned LFSR_W        = HPC_LFSR_W,
  parameter int unsigned RAND_W        = HPC_RAND_W,
  parameter int unsigned WARMUP_CYCLES = HPC_WARMUP_CYCLES,
  parameter int unsigned HEALTH_LIMIT  = HPC_HEALTH_LIMIT
) (
  input logic              clock_0,
  input logic              reset_0,
  hpc_rand_source_if.slave bus
);

  localparam int unsigned       WCNT_W   = $clog2(WARMUP_CYCLES + 1);
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(LFSR_TAPS_64);
  localparam logic [LFSR_W-1:0] ZERO_FIX = LFSR_W'(LFSR_ZERO_FIX);

  // Parameter sanity, rejected at elaboration
  if (LFSR_W != 64) begin : g_bad_lfsr_w
    $error("hpc_rand_source: tap set is defined for a 64-bit LFSR only");
  end
  if (RAND_W == 0 || RAND_W > LFSR_W) begin : g_bad_rand_w
    $error("hpc_rand_source: RAND_W must be in 1..LFSR_W");
  end
  if (WARMUP_CYCLES < min_warmup(LFSR_W, RAND_W)) begin : g_bad_warmup
    $error("hpc_rand_source: WARMUP_CYCLES below ceil(LFSR_W/RAND_W)");
  end
  if (HEALTH_LIMIT == 0) begin : g_bad_health
    $error("hpc_rand_source: HEALTH_LIMIT must be at least 1");
  end

  hpc_rand_state_e   state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_step_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [RAND_W-1:0] p_rand_q;
  logic              rand_valid_q;
  logic              seed_ready_q;
  logic              seed_acc_c;
  logic              alarm_c;

  // One cycle's worth of Galois steps from the current state
  hpc_lfsr_step #(
    .LFSR_W (LFSR_W),
    .STEPS  (RAND_W)
  ) u_step (
    .state_i (lfsr_q),
    .taps_i  (TAPS),
    .state_o (lfsr_step_d)
  );

  assign seed_acc_c = bus.io_seed_valid & seed_ready_q;

  // Control FSM; outputs are loaded alongside the LFSR so p_rand tracks its low bits
  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      state_q      <= UNSEEDED;
      lfsr_q       <= '0;
      wcnt_q       <= '0;
      p_rand_q     <= '0;
      rand_valid_q <= 1'b0;
      seed_ready_q <= 1'b1;
    end else if (seed_acc_c) begin
      // A seed always wins over a same-cycle step request
      state_q      <= WARMUP;
      lfsr_q       <= (bus.io_seed == '0) ? ZERO_FIX : bus.io_seed;
      wcnt_q       <= WCNT_W'(WARMUP_CYCLES);
      p_rand_q     <= '0;
      rand_valid_q <= 1'b0;
      seed_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        WARMUP: begin
          lfsr_q <= lfsr_step_d;
          if (wcnt_q == '0) begin
            state_q      <= RUN;
            p_rand_q     <= lfsr_step_d[RAND_W-1:0];
            rand_valid_q <= 1'b1;
            seed_ready_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        RUN: begin
          if (bus.io_rand_en) begin
            lfsr_q       <= lfsr_step_d;
            p_rand_q     <= alarm_c ? '0 : lfsr_step_d[RAND_W-1:0];
            rand_valid_q <= ~alarm_c;
          end
        end
        default: begin
          // UNSEEDED: idle until a seed arrives
        end
      endcase
    end
  end

`ifdef HPC_RAND_HEALTH_EN
  localparam int unsigned HCNT_W = $clog2(HEALTH_LIMIT + 1);

  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt_d;
  logic              health_fail_q;
  logic              run_step_c;
  logic              same_c;

  assign run_step_c = (state_q == RUN) && bus.io_rand_en && !seed_acc_c;
  assign same_c     = (lfsr_step_d[RAND_W-1:0] == p_rand_q);

  // Run length of identical consecutive outputs, saturating at the limit
  always_comb begin
    hcnt_d = hcnt_q;
    if (run_step_c) begin
      if (!same_c) begin
        hcnt_d = '0;
      end else if (hcnt_q != HCNT_W'(HEALTH_LIMIT)) begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end
  end

  assign alarm_c = health_fail_q | (run_step_c && (hcnt_d == HCNT_W'(HEALTH_LIMIT)));

  // Sticky alarm, cleared only by reset or a fresh seed
  always_ff @(posedge clock_0) begin
    if (reset_0 || seed_acc_c) begin
      hcnt_q        <= '0;
      health_fail_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      health_fail_q <= alarm_c;
    end
  end

  assign bus.io_health_fail = health_fail_q;
`else
  assign alarm_c            = 1'b0;
  assign bus.io_health_fail = 1'b0;
`endif

  assign bus.io_seed_ready = seed_ready_q;
  assign bus.p_rand        = p_rand_q;
  assign bus.io_rand_valid = rand_valid_q;

endmodule

// File: tb/tb_hpc_rand_source.sv
// tb_hpc_rand_source: randomized self-checking bench for hpc_rand_source.
// Reference: a bit-serial Galois LFSR advanced by whole cycles of 6 steps.
// Honors HPC_RAND_HEALTH_EN for the health alarm expectations.
module tb_hpc_rand_source;

  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hpc_rand_source_if #(.LFSR_W(64), .RAND_W(6)) bus ();

  hpc_rand_source #(
    .LFSR_W        (64),
    .RAND_W        (6),
    .WARMUP_CYCLES (16),
    .HEALTH_LIMIT  (8)
  ) dut (
    .clock_0 (clk),
    .reset_0 (rst),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  obs;
  logic [8:0]  exp_v;
  logic [63:0] m;

  // {seed_ready, rand_valid, p_rand[5:0], health_fail}
  assign obs = {bus.io_seed_ready, bus.io_rand_valid, bus.p_rand, bus.io_health_fail};

  // Reference: n cycles of 6 single-bit Galois right shifts each
  function automatic logic [63:0] adv(input logic [63:0] s, input int n);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < n * 6; i++) begin
      r = r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [63:0] s, input logic en);
    bus.io_seed       = s;
    bus.io_seed_valid = 1'b1;
    bus.io_rand_en    = en;
    tick();
    bus.io_seed_valid = 1'b0;
    bus.io_seed       = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_v = {1'b1, 1'b0, 6'd0, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_state: got %b want %b", obs, exp_v);
    if (obs !== exp_v) n_fail++;
    for (int i = 0; i < 8; i++) begin
      bus.io_rand_en = 1'($urandom);
      tick();
    end
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL unseeded_idle: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_warmup();
    do_seed({$urandom, $urandom}, 1'b0);
    exp_v = {1'b0, 1'b0, 6'd0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL warmup_entry: got %b want %b", obs, exp_v);
    end
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = {1'b1, 1'b0, 6'd0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_warmup: got %b want %b", obs, exp_v);
    end
    for (int i = 0; i < 20; i++) begin
      bus.io_rand_en = 1'($urandom);
      tick();
    end
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_stays_unseeded: got %b want %b", obs, exp_v);
    end
  endtask

  // Seed, check the 17-edge warm-up window, then run with random stalls
  task automatic test_warmup(input logic [63:0] seed, input logic acc_en, input int run_steps);
    logic        en;
    logic [63:0] start;
    start = (seed == 64'h0) ? 64'h1 : seed;
    do_seed(seed, acc_en);
    exp_v = {1'b0, 1'b0, 6'd0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL seed_accept seed=%h: got %b want %b", seed, obs, exp_v);
    end
    for (int c = 1; c <= 17; c++) begin
      bus.io_rand_en = 1'($urandom);
      tick();
      if (c < 17) begin
        exp_v = {1'b0, 1'b0, 6'd0, 1'b0};
      end else begin
        m     = adv(start, 17);
        exp_v = {1'b1, 1'b1, m[5:0], 1'b0};
      end
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL warmup seed=%h cycle=%0d: got %b want %b", seed, c, obs, exp_v);
      end
    end
    for (int i = 0; i < run_steps; i++) begin
      en = 1'($urandom);
      bus.io_rand_en = en;
      tick();
      if (en) m = adv(m, 1);
      exp_v = {1'b1, 1'b1, m[5:0], 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL run seed=%h step=%0d: got %b want %b", seed, i, obs, exp_v);
      end
    end
    bus.io_rand_en = 1'b0;
  endtask

  task automatic test_zero_seed();
    test_warmup(64'h0, 1'b0, 24);
  endtask

  task automatic test_hold();
    for (int r = 0; r < 3; r++) begin
      bus.io_rand_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        exp_v = {1'b1, 1'b1, m[5:0], 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL hold round=%0d cycle=%0d: got %b want %b", r, i, obs, exp_v);
        end
      end
      bus.io_rand_en = 1'b1;
      tick();
      m = adv(m, 1);
      exp_v = {1'b1, 1'b1, m[5:0], 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hold_release round=%0d: got %b want %b", r, obs, exp_v);
      end
    end
    bus.io_rand_en = 1'b0;
  endtask

  // Reseed from RUN with a same-cycle step request: the step is dropped
  task automatic test_reseed();
    test_warmup({$urandom, $urandom}, 1'b1, 10);
  endtask

  task automatic test_random_seeds();
    for (int k = 0; k < 3; k++) begin
      test_warmup({$urandom, $urandom}, 1'($urandom), 15);
    end
  endtask

  task automatic test_health();
    int trip_at;
    int steps;
    int want_trip;
    // A stuck-at-zero LFSR is indistinguishable from repeated zero outputs
    want_trip = (m[5:0] == 6'd0) ? 8 : 9;
    force dut.lfsr_q = 64'h0;
    bus.io_rand_en = 1'b1;
    tick();
    release dut.lfsr_q;
    steps   = 1;
    trip_at = (bus.io_health_fail === 1'b1) ? 1 : 0;
    while (steps < 12) begin
      tick();
      steps++;
      if (trip_at == 0 && bus.io_health_fail === 1'b1) trip_at = steps;
    end
    bus.io_rand_en = 1'b0;
`ifdef HPC_RAND_HEALTH_EN
    n_checks++;
    if (trip_at != want_trip) begin
      n_fail++;
      $display("FAIL health_trip_step: got %0d want %0d", trip_at, want_trip);
    end
    exp_v = {1'b1, 1'b0, 6'd0, 1'b1};
`else
    n_checks++;
    if (trip_at != 0) begin
      n_fail++;
      $display("FAIL health_disabled: got trip at %0d want none (ref %0d)", trip_at, want_trip);
    end
    exp_v = {1'b1, 1'b1, 6'd0, 1'b0};
`endif
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL health_outputs: got %b want %b", obs, exp_v);
    end
    // A fresh seed clears the alarm and restarts normally
    test_warmup({$urandom, $urandom}, 1'b0, 8);
  endtask

  initial begin
    rst               = 1'b1;
    bus.io_seed       = '0;
    bus.io_seed_valid = 1'b0;
    bus.io_rand_en    = 1'b0;
    test_reset();
    test_reset_mid_warmup();
    test_warmup(64'h0123_4567_89AB_CDEF, 1'b0, 40);
    test_zero_seed();
    test_hold();
    test_reseed();
    test_random_seeds();
    test_health();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
